sample_byte_fifo: RTL and testbench

//  Upstream stage of the serial master interface. Accepts 16-bit samples from
//  the acquisition path, splits each into two bytes (low byte first) and buffers

---
 rtl/sample_byte_fifo.sv | 143 ++++++++++++++
 tb/tb_sample_byte_fifo.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sample_byte_fifo.sv
// Sample-to-byte packer feeding a byte FIFO that the serial master drains one byte per read strobe.
// A 16-bit sample is stored low byte first; both bytes are reserved before the low byte is accepted.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   LO_S  | idle / accepting a sample; writes din[7:0] on acceptance
//   HI_S  | writing the latched high byte; no sample accepted
module sample_byte_fifo #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          din_valid,
    input  logic [15:0]   din,
    output logic          din_ready,
    input  logic          flush,
    input  logic          fifoRd,
    output logic [7:0]    rdata,
    output logic [AW-1:0] wrcnt,
    output logic          empty,
    output logic          ovf,
    output logic          unf
);

    typedef enum logic {
        LO_S = 1'b0,
        HI_S = 1'b1
    } state_t;

    // Highest occupancy at which two more bytes still fit (free >= 2).
    localparam logic [AW-1:0] LO_MAX = AW'(DEPTH - 3);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [7:0]    hi_q;
    logic          alive;
    logic          room2;
    logic          wr_en;
    logic [7:0]    wr_byte;
    logic          hi_load;
    logic          ovf_set;
    logic          rd_en;
    logic          unf_set;
    logic [7:0]    mem [DEPTH];

    assign empty = (wrcnt == '0);
    assign room2 = (wrcnt <= LO_MAX);
    assign rd_en   = fifoRd & ~empty & ~flush;
    assign unf_set = fifoRd &  empty & ~flush;

    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        wr_en     = 1'b0;
        wr_byte   = din[7:0];
        hi_load   = 1'b0;
        ovf_set   = 1'b0;
        case (state)
            LO_S: begin
                // alive keeps din_ready low while reset is held and for the release cycle
                din_ready = alive & room2;
                if (din_valid && din_ready) begin
                    wr_en     = 1'b1;
                    hi_load   = 1'b1;
                    state_nxt = HI_S;
                end else if (din_valid && !room2) begin
                    ovf_set = 1'b1;
                end
            end
            HI_S: begin
                wr_en     = 1'b1;
                wr_byte   = hi_q;
                state_nxt = LO_S;
            end
            default: state_nxt = LO_S;
        endcase
        if (flush) begin
            state_nxt = LO_S;
            wr_en     = 1'b0;
            hi_load   = 1'b0;
            ovf_set   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= LO_S;
            alive  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            wrcnt  <= '0;
            hi_q   <= 8'h00;
            rdata  <= 8'h00;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            alive <= 1'b1;
            state <= state_nxt;
            if (hi_load) begin
                hi_q <= din[15:8];
            end
            if (rd_en) begin
                rdata <= mem[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                wrcnt  <= '0;
                ovf    <= 1'b0;
                unf    <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({wr_en, rd_en})
                    2'b10:   wrcnt <= wrcnt + AW'(1);
                    2'b01:   wrcnt <= wrcnt - AW'(1);
                    default: wrcnt <= wrcnt;
                endcase
                if (ovf_set) begin
                    ovf <= 1'b1;
                end
                if (unf_set) begin
                    unf <= 1'b1;
                end
            end
        end
    end

    // Storage has no reset so it can map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_byte;
        end
    end

endmodule

// File: tb/tb_sample_byte_fifo.sv
// Scoreboard bench for sample_byte_fifo: bytes are queued as samples are driven
// and compared against rdata as each read strobe completes.
module tb_sample_byte_fifo;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          arst;
    logic          din_valid;
    logic [15:0]   din;
    logic          din_ready;
    logic          flush;
    logic          fifoRd;
    logic [7:0]    rdata;
    logic [AW-1:0] wrcnt;
    logic          empty;
    logic          ovf;
    logic          unf;

    int        n_cmp = 0;
    int        n_err = 0;
    logic [7:0] q[$];
    logic [7:0] m_rdata = 8'h00;

    sample_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .arst      (arst),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .flush     (flush),
        .fifoRd    (fifoRd),
        .rdata     (rdata),
        .wrcnt     (wrcnt),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [15:0] s);
        din       = s;
        din_valid = 1'b1;
        q.push_back(s[7:0]);
        q.push_back(s[15:8]);
        step();
        din_valid = 1'b0;
        step();
        chk("push_cnt", 32'(wrcnt), 32'(q.size()));
    endtask

    task automatic read_byte(input string tag);
        fifoRd = 1'b1;
        if (q.size() > 0) m_rdata = q.pop_front();
        step();
        fifoRd = 1'b0;
        chk(tag, 32'(rdata), 32'(m_rdata));
        chk("read_cnt", 32'(wrcnt), 32'(q.size()));
    endtask

    initial begin
        logic [15:0] s;
        int          phase;

        arst      = 1'b1;
        din_valid = 1'b0;
        din       = 16'h0000;
        flush     = 1'b0;
        fifoRd    = 1'b0;
        #23;
        chk("rst_cnt",   32'(wrcnt), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(din_ready), 32'd0);
        chk("rst_ovf",   32'(ovf), 32'd0);
        chk("rst_unf",   32'(unf), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        step();
        arst = 1'b0;
        step();
        chk("ready_after_rst", 32'(din_ready), 32'd1);

        // single sample: low byte first, ready drops while the high byte is written
        din       = 16'hA1B2;
        din_valid = 1'b1;
        q.push_back(8'hB2);
        q.push_back(8'hA1);
        step();
        din_valid = 1'b0;
        chk("t1_cnt1",  32'(wrcnt), 32'd1);
        chk("t1_hi_rdy", 32'(din_ready), 32'd0);
        step();
        chk("t1_cnt2",  32'(wrcnt), 32'd2);
        chk("t1_lo_rdy", 32'(din_ready), 32'd1);

        read_byte("t2_rd0");
        read_byte("t2_rd1");
        chk("t2_unf_pre", 32'(unf), 32'd0);
        read_byte("t2_rd_empty");
        chk("t2_unf",   32'(unf), 32'd1);
        chk("t2_empty", 32'(empty), 32'd1);

        // fill to 1022 bytes: the last sample is accepted at free==3, then blocked at free==1
        for (int i = 0; i < 511; i++) push_sample(16'($urandom));
        chk("t3_cnt",   32'(wrcnt), 32'd1022);
        chk("t3_ready", 32'(din_ready), 32'd0);
        chk("t3_ovf_pre", 32'(ovf), 32'd0);
        din       = 16'hDEAD;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("t3_ovf",      32'(ovf), 32'd1);
        chk("t3_cnt_hold", 32'(wrcnt), 32'd1022);

        for (int i = 0; i < 22; i++) read_byte("t4_drain");
        chk("t4_start", 32'(wrcnt), 32'd1000);

        // streaming: one byte in and one byte out every cycle, pointers wrap
        phase = 0;
        for (int i = 0; i < 2000; i++) begin
            fifoRd    = 1'b1;
            din_valid = 1'b1;
            if (phase == 0) begin
                s   = 16'($urandom);
                din = s;
                q.push_back(s[7:0]);
                q.push_back(s[15:8]);
            end
            m_rdata = q.pop_front();
            step();
            phase ^= 1;
            chk("t4_data", 32'(rdata), 32'(m_rdata));
            chk("t4_cnt",  32'(wrcnt), 32'(q.size() - phase));
            chk("t4_rdy",  32'(din_ready), 32'(phase == 0));
        end
        fifoRd    = 1'b0;
        din_valid = 1'b0;
        step();
        chk("t4_end_cnt", 32'(wrcnt), 32'd1000);

        // reset in the middle of a sample with 300 bytes stored
        for (int i = 0; i < 700; i++) read_byte("t5_drain");
        din       = 16'h1357;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        chk("t5_pre_cnt", 32'(wrcnt), 32'd301);
        chk("t5_pre_hi",  32'(din_ready), 32'd0);
        arst = 1'b1;
        #1;
        chk("t5_cnt",   32'(wrcnt), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_rdy",   32'(din_ready), 32'd0);
        chk("t5_ovf",   32'(ovf), 32'd0);
        q.delete();
        m_rdata = 8'h00;
        step();
        arst = 1'b0;
        step();
        chk("t5_rdy_rel", 32'(din_ready), 32'd1);
        push_sample(16'h5A3C);
        read_byte("t5_lo");
        read_byte("t5_hi");

        // flush beats concurrent sample and read strobe
        read_byte("t6_unf_rd");
        chk("t6_unf_set", 32'(unf), 32'd1);
        push_sample(16'h7788);
        read_byte("t6_lo");
        flush     = 1'b1;
        din       = 16'h1234;
        din_valid = 1'b1;
        fifoRd    = 1'b1;
        step();
        flush     = 1'b0;
        din_valid = 1'b0;
        fifoRd    = 1'b0;
        q.delete();
        chk("t6_cnt",   32'(wrcnt), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_unf",   32'(unf), 32'd0);
        chk("t6_ovf",   32'(ovf), 32'd0);
        chk("t6_rdata", 32'(rdata), 32'h88);
        step();
        chk("t6_no_wr", 32'(wrcnt), 32'd0);
        push_sample(16'hCAFE);
        read_byte("t6_after_lo");
        read_byte("t6_after_hi");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
